// File: rtl/defuse_pkg.sv
// Shared types for the bomb-defuse round monitor.
package defuse_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ARMED    = 2'b01,
        DEFUSED  = 2'b10,
        EXPLODED = 2'b11
    } state_t;

    localparam int STRIKE_W = 4;

endpackage

// File: rtl/wire_debounce.sv
// One wire-sense input: two-flop synchroniser followed by a debounce counter
// that accepts a new level only after DEBOUNCE_CYCLES consecutive agreeing samples.
module wire_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_q;
    logic [CNT_W-1:0] cnt;

    // Any sample that agrees with the accepted level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            cnt       <= '0;
            dout      <= 1'b0;
        end else begin
            sync_meta <= din;
            sync_q    <= sync_meta;
            if (sync_q != dout) begin
                if (cnt == CNT_LAST) begin
                    dout <= sync_q;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/defuse_monitor.sv
// Bomb-defuse round monitor: debounced wire sensing, countdown timer,
// trap-strike counting and DEFUSED/EXPLODED resolution.
module defuse_monitor #(
    parameter int N_WIRES         = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMER_W         = 16,
    parameter int MAX_STRIKES     = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_WIRES-1:0] wire_in,
    input  logic [N_WIRES-1:0] trap_mask,
    input  logic [TIMER_W-1:0] timeout_load,
    input  logic               tick,
    input  logic               arm,
    input  logic               clear,
    output logic [1:0]         state,
    output logic               defused,
    output logic               exploded,
    output logic               arm_err,
    output logic [TIMER_W-1:0] time_left,
    output logic [3:0]         strikes,
    output logic [N_WIRES-1:0] cut_status
);

    import defuse_pkg::*;

    localparam int PC_W  = $clog2(N_WIRES + 1);
    localparam int SUM_W = ((PC_W > STRIKE_W) ? PC_W : STRIKE_W) + 1;
    localparam logic [STRIKE_W-1:0] STRIKE_MAX = STRIKE_W'(MAX_STRIKES);

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   time_q, time_d;
    logic [STRIKE_W-1:0]  strikes_q, strikes_d;
    logic [N_WIRES-1:0]   trap_q, trap_d;
    logic [N_WIRES-1:0]   cut_prev;
    logic                 arm_err_q, arm_err_d;
    logic                 defused_q, exploded_q;

    logic [N_WIRES-1:0]   new_trap;
    logic [PC_W-1:0]      trap_count;
    logic [SUM_W-1:0]     strike_sum;
    logic [STRIKE_W-1:0]  strikes_sat;

    for (genvar g = 0; g < N_WIRES; g++) begin : g_wire
        wire_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (wire_in[g]),
            .dout (cut_status[g])
        );
    end

    // Only fresh cuts of trap wires strike; reconnecting never refunds one.
    always_comb begin
        new_trap   = cut_status & ~cut_prev & trap_q;
        trap_count = '0;
        for (int i = 0; i < N_WIRES; i++) begin
            trap_count = trap_count + PC_W'(new_trap[i]);
        end
        strike_sum  = SUM_W'(strikes_q) + SUM_W'(trap_count);
        strikes_sat = (strike_sum >= SUM_W'(MAX_STRIKES)) ? STRIKE_MAX
                                                           : strike_sum[STRIKE_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        strikes_d = strikes_q;
        trap_d    = trap_q;
        arm_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    if (timeout_load == '0 || |cut_status) begin
                        arm_err_d = 1'b1;
                    end else begin
                        trap_d    = trap_mask;
                        time_d    = timeout_load;
                        strikes_d = '0;
                        state_d   = ARMED;
                    end
                end
            end
            ARMED: begin
                if (clear) begin
                    state_d = IDLE;
                end else begin
                    strikes_d = strikes_sat;
                    if (strikes_sat == STRIKE_MAX) begin
                        state_d = EXPLODED;
                    end else if (&(cut_status | trap_q)) begin
                        state_d = DEFUSED;
                    end else if (tick && time_q == TIMER_W'(1)) begin
                        time_d  = '0;
                        state_d = EXPLODED;
                    end else if (tick && time_q != '0) begin
                        time_d = time_q - 1'b1;
                    end
                end
            end
            DEFUSED, EXPLODED: begin
                if (clear) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            time_q     <= '0;
            strikes_q  <= '0;
            trap_q     <= '0;
            cut_prev   <= '0;
            arm_err_q  <= 1'b0;
            defused_q  <= 1'b0;
            exploded_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            strikes_q  <= strikes_d;
            trap_q     <= trap_d;
            cut_prev   <= cut_status;
            arm_err_q  <= arm_err_d;
            defused_q  <= (state_d == DEFUSED);
            exploded_q <= (state_d == EXPLODED);
        end
    end

    assign state     = state_q;
    assign defused   = defused_q;
    assign exploded  = exploded_q;
    assign arm_err   = arm_err_q;
    assign time_left = time_q;
    assign strikes   = strikes_q;

endmodule

// File: doc/defuse_monitor.md
Name: defuse_monitor

Overview:
Parametrised successor to the team's combinational "all wires cut" detector for the bomb-defuse game board. It synchronises and debounces N wire-sense inputs and arms a countdown timer. It classifies each cut as required or trap, counts strikes, and resolves the round to DEFUSED or EXPLODED. It sits between the wire-sense pins and the display/buzzer logic.

Parameters:
N_WIRES, 8, number of wire-sense inputs (1..32)
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a change (>=1)
TIMER_W, 16, width of countdown timer
MAX_STRIKES, 3, trap cuts tolerated before explosion (1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wire_in  in  N_WIRES  raw wire sense, 1 = wire cut, asynchronous
trap_mask  in  N_WIRES  1 = trap wire; sampled only on accepted arm
timeout_load  in  TIMER_W  initial time in ticks; sampled only on accepted arm
tick  in  1  one-cycle timer decrement strobe (e.g. 1 Hz enable)
arm  in  1  one-cycle start request
clear  in  1  one-cycle return to IDLE
state  out  2  00 IDLE, 01 ARMED, 10 DEFUSED, 11 EXPLODED
defused  out  1  high while state==DEFUSED
exploded  out  1  high while state==EXPLODED
arm_err  out  1  one-cycle pulse, arm rejected
time_left  out  TIMER_W  remaining ticks
strikes  out  4  trap cuts counted this round, saturating at MAX_STRIKES
cut_status  out  N_WIRES  debounced wire state

Behaviour:
- Reset (async assert, sync release): state=IDLE, defused=0, exploded=0, arm_err=0, time_left=0, strikes=0, cut_status=0, latched trap mask=0, debounce counters=0.
- Input path per wire: 2-flop synchroniser, then debounce counter. cut_status[i] toggles only after the synchronised value differs from cut_status[i] for DEBOUNCE_CYCLES consecutive cycles. Any mismatch gap resets that counter. Latency from a clean input edge to cut_status is 2+DEBOUNCE_CYCLES cycles.
- All outputs are registered. The FSM reacts to cut_status in the cycle after it changes.
- IDLE:
  - On arm: if timeout_load==0 or any cut_status bit is 1, pulse arm_err and stay in IDLE.
  - Otherwise latch trap_mask, set time_left=timeout_load, set strikes=0, and go to ARMED.
  - clear is a no-op.
- ARMED:
  - required = ~latched_trap. new_trap = rising edges of cut_status & latched_trap. A falling edge (reconnect) never removes a strike.
  - strikes_next = min(strikes + popcount(new_trap), MAX_STRIKES).
  - Priority within one cycle:
    - (1) strikes_next==MAX_STRIKES -> EXPLODED.
    - (2) all required bits of cut_status ==1 -> DEFUSED. If every wire is a trap, this holds immediately.
    - (3) tick && time_left==1 -> time_left=0, EXPLODED.
    - (4) otherwise, tick decrements time_left.
  - arm is ignored. clear aborts to IDLE and keeps time_left/strikes for display.
  - A reconnected required wire is no longer counted as cut. Defuse needs all required wires cut in the same cycle.
- DEFUSED/EXPLODED: time_left and strikes are frozen. arm is ignored. clear -> IDLE.
- Reset mid-round returns to IDLE immediately. There is no recovery of round state.
- Widths: strikes is 4 bits; popcount is computed at clog2(N_WIRES+1) bits and then saturated. time_left never underflows.

Decomposition:
- Package defuse_pkg: state enum (IDLE, ARMED, DEFUSED, EXPLODED) with its 2-bit encoding, and a STRIKE_W=4 constant.
- Sub-module wire_debounce: 1-bit synchroniser plus debounce counter, parameter DEBOUNCE_CYCLES. It is instantiated N_WIRES times in a generate loop.
- The FSM, timer, strike counter and popcount live in defuse_monitor.

Test Plan:
- Glitch reject (DEBOUNCE_CYCLES=4): wire_in[0] pulses high for 3 cycles -> cut_status stays 0. Held high -> cut_status[0]=1 exactly 6 cycles after the edge.
- Clean defuse: arm with trap_mask=8'h81, timeout_load=10; cut wires 1..6 with no ticks -> DEFUSED one cycle after cut_status==8'h7E, time_left=10, strikes=0.
- Timeout: arm with timeout_load=3, no cuts, 3 ticks -> time_left 2,1,0, then EXPLODED on the third tick.
- Strikes with MAX_STRIKES=3: cut trap wire 0, then trap wire 7 -> strikes=2, still ARMED. Reconnect and recut wire 0 -> strikes=3 and EXPLODED.
- Simultaneous events: final required wire cut and a trap cut accepted in the same cycle with strikes=1 -> DEFUSED, strikes=2. With strikes=2 -> EXPLODED. Last tick with time_left=1 coinciding with defuse completion -> DEFUSED, time_left=1.
- Arm rejects and reset: arm with timeout_load=0 -> arm_err pulses 1 cycle, state stays IDLE. arm with cut_status!=0 -> arm_err. rst_n low mid-ARMED -> all outputs return to reset values asynchronously.
